// File: rtl/axis_symbol_decimator.sv
`default_nettype none
// ============================================================================
// Module   : axis_symbol_decimator
// Purpose  : Picks one IQ sample per symbol (external strobe or every-Nth
//            counter), buffers it in an FWFT FIFO and re-packetises output.
// Option   : AXIS_SYMBOL_DECIMATOR_DROP_ON_FULL_EN - drop captures on full
//            instead of back-pressuring; adds overflow_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module axis_symbol_decimator #(
    parameter int WIDTH           = 32,
    parameter int FIFO_DEPTH_LOG2 = 5,
    parameter int SPP_WIDTH       = 16,
    parameter int DECIM_WIDTH     = 8
) (
    input  logic                       ce_clk,
    input  logic                       ce_rst,
    input  logic                       clear,
    input  logic                       cfg_mode,
    input  logic [DECIM_WIDTH-1:0]     cfg_decim,
    input  logic [SPP_WIDTH-1:0]       cfg_spp,
    input  logic                       sym_stb,
    input  logic [WIDTH-1:0]           s_axis_tdata,
    input  logic                       s_axis_tlast,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    output logic [WIDTH-1:0]           m_axis_tdata,
    output logic                       m_axis_tlast,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [FIFO_DEPTH_LOG2:0]   fill_level
`ifdef AXIS_SYMBOL_DECIMATOR_DROP_ON_FULL_EN
    ,
    output logic [15:0]                overflow_cnt
`endif
);

    localparam int                     c_DEPTH = 2 ** FIFO_DEPTH_LOG2;
    localparam logic [FIFO_DEPTH_LOG2:0] c_FULL = (FIFO_DEPTH_LOG2 + 1)'(c_DEPTH);

    logic                       w_flush;
    logic                       w_full;
    logic                       w_accept;
    logic [DECIM_WIDTH-1:0]     w_decim_m1;
    logic                       w_capture;
    logic                       w_last;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_load;
    logic                       w_mem_empty;
    logic                       w_mem_wr;
    logic [WIDTH:0]             w_push_word;

    logic                       r_mode_q;
    logic [DECIM_WIDTH-1:0]     r_phase;
    logic [SPP_WIDTH-1:0]       r_sym_cnt;
    logic                       r_pend_eop;
    logic [WIDTH:0]             r_mem [0:c_DEPTH-1];
    logic [FIFO_DEPTH_LOG2-1:0] r_wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0] r_rd_ptr;
    logic [FIFO_DEPTH_LOG2:0]   r_fill;
    logic                       r_out_valid;
    logic                       r_out_last;
    logic [WIDTH-1:0]           r_out_data;

    assign w_flush    = ce_rst | clear;
    assign w_full     = (r_fill == c_FULL);
    assign w_accept   = s_axis_tvalid & s_axis_tready;
    assign w_decim_m1 = (cfg_decim == '0) ? '0 : cfg_decim - DECIM_WIDTH'(1);
    assign w_capture  = w_accept & (cfg_mode ? (r_phase == w_decim_m1) : sym_stb);
    assign w_last     = s_axis_tlast | r_pend_eop |
                        ((cfg_spp != '0) && (r_sym_cnt >= (cfg_spp - SPP_WIDTH'(1))));
    assign w_push_word = {w_last, s_axis_tdata};
    assign w_pop      = r_out_valid & m_axis_tready;

`ifdef AXIS_SYMBOL_DECIMATOR_DROP_ON_FULL_EN
    logic        w_drop;
    logic [15:0] r_overflow_cnt;

    // A pop in the same cycle frees the slot, so only a non-popping full FIFO drops.
    assign w_push        = w_capture & (~w_full | w_pop);
    assign w_drop        = w_capture & w_full & ~w_pop;
    assign s_axis_tready = ~ce_rst & ~clear;
    assign overflow_cnt  = r_overflow_cnt;

    always_ff @(posedge ce_clk) begin
        if (w_flush) begin
            r_overflow_cnt <= '0;
        end else if (w_drop && (r_overflow_cnt != 16'hFFFF)) begin
            r_overflow_cnt <= r_overflow_cnt + 16'd1;
        end
    end
`else
    assign w_push        = w_capture;
    assign s_axis_tready = ~w_full & ~ce_rst & ~clear;
`endif

    // Mode tracker follows the config input unconditionally; config is never reset.
    always_ff @(posedge ce_clk) begin
        r_mode_q <= cfg_mode;
    end

    always_ff @(posedge ce_clk) begin
        if (w_flush) begin
            r_phase    <= '0;
            r_sym_cnt  <= '0;
            r_pend_eop <= 1'b0;
        end else begin
            if (cfg_mode != r_mode_q) begin
                r_phase <= '0;
            end else if (cfg_mode && w_accept) begin
                r_phase <= (r_phase >= w_decim_m1) ? '0 : r_phase + DECIM_WIDTH'(1);
            end
            if (w_capture) begin
                if (w_last) begin
                    r_sym_cnt  <= '0;
                    r_pend_eop <= 1'b0;
                end else begin
                    r_sym_cnt  <= r_sym_cnt + SPP_WIDTH'(1);
                end
            end else if (w_accept && s_axis_tlast) begin
                r_pend_eop <= 1'b1;
            end
        end
    end

    // The output register is the FIFO head; the RAM holds everything behind it.
    assign w_load      = ~r_out_valid | w_pop;
    assign w_mem_empty = (r_wr_ptr == r_rd_ptr);
    assign w_mem_wr    = w_push & ~(w_load & w_mem_empty);

    always_ff @(posedge ce_clk) begin
        if (w_mem_wr) begin
            r_mem[r_wr_ptr] <= w_push_word;
        end
    end

    always_ff @(posedge ce_clk) begin
        if (w_flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_fill      <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (w_mem_wr) begin
                r_wr_ptr <= r_wr_ptr + FIFO_DEPTH_LOG2'(1);
            end
            if (w_load) begin
                if (!w_mem_empty) begin
                    {r_out_last, r_out_data} <= r_mem[r_rd_ptr];
                    r_out_valid              <= 1'b1;
                    r_rd_ptr                 <= r_rd_ptr + FIFO_DEPTH_LOG2'(1);
                end else if (w_push) begin
                    {r_out_last, r_out_data} <= w_push_word;
                    r_out_valid              <= 1'b1;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + (FIFO_DEPTH_LOG2 + 1)'(1);
                2'b01:   r_fill <= r_fill - (FIFO_DEPTH_LOG2 + 1)'(1);
                default: r_fill <= r_fill;
            endcase
        end
    end

    assign m_axis_tdata  = r_out_data;
    assign m_axis_tlast  = r_out_last;
    assign m_axis_tvalid = r_out_valid;
    assign fill_level    = r_fill;

endmodule
`default_nettype wire

// File: tb/tb_axis_symbol_decimator.sv
`default_nettype none
// Bench for axis_symbol_decimator: directed scenarios plus random traffic,
// checked every cycle against a queue-based model of the symbol stream.
module tb_axis_symbol_decimator;

    localparam int DEPTH = 32;
`ifdef AXIS_SYMBOL_DECIMATOR_DROP_ON_FULL_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic        ce_clk = 1'b0;
    logic        ce_rst;
    logic        clear;
    logic        cfg_mode;
    logic [7:0]  cfg_decim;
    logic [15:0] cfg_spp;
    logic        sym_stb;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tlast;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [5:0]  fill_level;
`ifdef AXIS_SYMBOL_DECIMATOR_DROP_ON_FULL_EN
    logic [15:0] overflow_cnt;
`endif

    always #5 ce_clk = ~ce_clk;

    axis_symbol_decimator dut (
        .ce_clk        (ce_clk),
        .ce_rst        (ce_rst),
        .clear         (clear),
        .cfg_mode      (cfg_mode),
        .cfg_decim     (cfg_decim),
        .cfg_spp       (cfg_spp),
        .sym_stb       (sym_stb),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
`ifdef AXIS_SYMBOL_DECIMATOR_DROP_ON_FULL_EN
        .overflow_cnt  (overflow_cnt),
`endif
        .fill_level    (fill_level)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [32:0] mq[$];
    logic [32:0] got[$];
    int          m_phase = 0;
    int          m_cnt = 0;
    bit          m_pend = 1'b0;
    bit          m_prev_mode = 1'b0;
    int          m_ovf = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check outputs against the model, advance the model.
    task automatic cyc(input bit v, input logic [31:0] d, input bit l, input bit stb, input bit rdy);
        bit          exp_rdy, acc, cap, lst, pop;
        int          dm;
        s_axis_tvalid = v;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        sym_stb       = stb;
        m_axis_tready = rdy;
        #1;
        exp_rdy = !(ce_rst || clear) && (DROP || mq.size() < DEPTH);
        chk("s_tready", 64'(s_axis_tready), 64'(exp_rdy));
        chk("m_tvalid", 64'(m_axis_tvalid), 64'(mq.size() != 0));
        chk("fill_level", 64'(fill_level), 64'(mq.size()));
        if (mq.size() != 0) chk("m_beat", 64'({m_axis_tlast, m_axis_tdata}), 64'(mq[0]));
`ifdef AXIS_SYMBOL_DECIMATOR_DROP_ON_FULL_EN
        chk("overflow_cnt", 64'(overflow_cnt), 64'(m_ovf));
`endif
        pop = (mq.size() != 0) && rdy;
        acc = v && exp_rdy;
        dm  = (cfg_decim == 0) ? 1 : int'(cfg_decim);
        cap = acc && (cfg_mode ? (m_phase == dm - 1) : stb);
        lst = l || m_pend || (cfg_spp != 0 && m_cnt >= int'(cfg_spp) - 1);
        @(posedge ce_clk);
        #1;
        if (pop) got.push_back(mq.pop_front());
        if (ce_rst || clear) begin
            mq.delete();
            m_phase = 0;
            m_cnt   = 0;
            m_pend  = 1'b0;
            m_ovf   = 0;
        end else begin
            if (cap) begin
                if (mq.size() < DEPTH) mq.push_back({lst, d});
                else if (m_ovf < 65535) m_ovf++;
                if (lst) begin
                    m_cnt  = 0;
                    m_pend = 1'b0;
                end else begin
                    m_cnt++;
                end
            end else if (acc && l) begin
                m_pend = 1'b1;
            end
            if (cfg_mode != m_prev_mode) m_phase = 0;
            else if (cfg_mode && acc) m_phase = (m_phase + 1) % dm;
        end
        m_prev_mode = cfg_mode;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic reconfig(input bit mode, input int decim, input int spp);
        cfg_mode  = mode;
        cfg_decim = 8'(decim);
        cfg_spp   = 16'(spp);
        clear     = 1'b1;
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        clear     = 1'b0;
        idle(2);
        got.delete();
    endtask

    initial begin
        ce_rst = 1'b1; clear = 1'b0;
        cfg_mode = 1'b0; cfg_decim = 8'd1; cfg_spp = 16'd0;
        sym_stb = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0;
        s_axis_tvalid = 1'b0; m_axis_tready = 1'b0;
        @(posedge ce_clk);
        #1;
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("rst_tdata", 64'(m_axis_tdata), 64'd0);
        chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
        ce_rst = 1'b0;
        idle(2);

        // Internal ratio 4, no length tlast
        reconfig(1'b1, 4, 0);
        for (int i = 0; i < 16; i++) cyc(1'b1, 32'(i), 1'b0, 1'b0, 1'b1);
        idle(3);
        chk("t1_count", 64'(got.size()), 64'd4);
        for (int k = 0; k < 4 && k < got.size(); k++)
            chk("t1_sym", 64'(got[k]), 64'({1'b0, 32'(4 * k + 3)}));

        // Internal ratio 2, three symbols per packet
        reconfig(1'b1, 2, 3);
        for (int i = 0; i < 12; i++) cyc(1'b1, 32'(i), 1'b0, 1'b0, 1'b1);
        idle(3);
        chk("t2_count", 64'(got.size()), 64'd6);
        for (int k = 0; k < 6 && k < got.size(); k++)
            chk("t2_sym", 64'(got[k]), 64'({(k == 2 || k == 5), 32'(2 * k + 1)}));

        // External strobe, input tlast on a non-captured beat
        reconfig(1'b0, 1, 0);
        for (int i = 0; i < 8; i++) cyc(1'b1, 32'(100 + i), (i == 4), (i == 2 || i == 6), 1'b1);
        idle(3);
        chk("t3a_count", 64'(got.size()), 64'd2);
        if (got.size() == 2) begin
            chk("t3a_sym0", 64'(got[0]), 64'({1'b0, 32'd102}));
            chk("t3a_sym1", 64'(got[1]), 64'({1'b1, 32'd106}));
        end

        // External strobe, tlast on the captured beat itself
        reconfig(1'b0, 1, 0);
        for (int i = 0; i < 8; i++) cyc(1'b1, 32'(100 + i), (i == 2), (i == 2 || i == 6), 1'b1);
        idle(3);
        chk("t3b_count", 64'(got.size()), 64'd2);
        if (got.size() == 2) begin
            chk("t3b_sym0", 64'(got[0]), 64'({1'b1, 32'd102}));
            chk("t3b_sym1", 64'(got[1]), 64'({1'b0, 32'd106}));
        end

        // Output stall with every sample captured
        reconfig(1'b1, 1, 0);
        for (int i = 0; i < 40; i++) cyc(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
        s_axis_tvalid = 1'b0;
        #1;
        chk("t4_fill", 64'(fill_level), 64'd32);
        chk("t4_tready", 64'(s_axis_tready), 64'(DROP));
`ifdef AXIS_SYMBOL_DECIMATOR_DROP_ON_FULL_EN
        chk("t4_overflow", 64'(overflow_cnt), 64'd8);
`endif
        idle(40);
        chk("t4_count", 64'(got.size()), 64'd32);
        for (int k = 0; k < 32 && k < got.size(); k++)
            chk("t4_sym", 64'(got[k]), 64'({1'b0, 32'(k)}));

        // Reset in the middle of a packet
        reconfig(1'b1, 1, 3);
        for (int i = 0; i < 5; i++) cyc(1'b1, 32'(200 + i), 1'b0, 1'b0, 1'b0);
        chk("t5_fill_pre", 64'(fill_level), 64'd5);
        ce_rst = 1'b1;
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        ce_rst = 1'b0;
        s_axis_tvalid = 1'b0;
        #1;
        chk("t5_fill_post", 64'(fill_level), 64'd0);
        chk("t5_tvalid_post", 64'(m_axis_tvalid), 64'd0);
        idle(2);
        got.delete();
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'(300 + i), 1'b0, 1'b0, 1'b1);
        idle(3);
        chk("t5_count", 64'(got.size()), 64'd3);
        for (int k = 0; k < 3 && k < got.size(); k++)
            chk("t5_sym", 64'(got[k]), 64'({(k == 2), 32'(300 + k)}));

        // Random traffic under several configurations
        for (int seg = 0; seg < 6; seg++) begin
            reconfig(seg[0], int'($urandom_range(0, 5)), int'($urandom_range(0, 4)));
            for (int i = 0; i < 150; i++)
                cyc(($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 7) == 0),
                    $urandom_range(0, 1) == 1, ($urandom_range(0, 3) != 0));
            idle(40);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axis_symbol_decimator.md
Name: axis_symbol_decimator

Overview:
- Parametrised symbol-rate decimator for the demodulator chain; sits between the carrier-recovery output and the axi_wrapper s_axis_data port.
- Picks one IQ sample per symbol, either on an external bit-sync strobe or on an internal every-Nth-sample counter.
- Buffers the picked symbols in a FIFO with proper AXI-stream backpressure.
- Re-packetises the output: tlast every cfg_spp symbols, or at input end-of-packet.

Parameters:
- WIDTH, 32, sample/symbol data width in bits (packed {I,Q}).
- FIFO_DEPTH_LOG2, 5, log2 of output FIFO depth (default 32 entries).
- SPP_WIDTH, 16, width of the symbols-per-packet config field.
- DECIM_WIDTH, 8, width of the internal decimation-ratio config field.

Ports:
- ce_clk  in  1  block clock.
- ce_rst  in  1  reset; synchronous, active-high.
- clear  in  1  synchronous flush of FIFO, counters and pending flags; config inputs unaffected.
- cfg_mode  in  1  strobe source: 0 = external sym_stb, 1 = internal decimation counter.
- cfg_decim  in  DECIM_WIDTH  internal ratio N: capture 1 of every N accepted samples; 0 is treated as 1.
- cfg_spp  in  SPP_WIDTH  symbols per output packet; 0 = length-based tlast disabled.
- sym_stb  in  1  external bit-sync strobe; qualifies the sample on the same-cycle input handshake.
- s_axis_tdata  in  WIDTH  input samples.
- s_axis_tlast  in  1  input end-of-packet.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  WIDTH  output symbols.
- m_axis_tlast  out  1  output end-of-packet.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- fill_level  out  FIFO_DEPTH_LOG2+1  current FIFO occupancy.

Behaviour:
- Reset and clear values: ce_rst clears m_axis_tvalid, m_axis_tlast, m_axis_tdata, fill_level, phase counter, symbol counter and pend_eop to 0. s_axis_tready is 0 while ce_rst is high.
- clear does the same except s_axis_tready, which is 0 for the clear cycle only.
- Accept: a beat is accepted when s_axis_tvalid & s_axis_tready.
- Capture (mode 0): an accepted beat with sym_stb=1 is captured. sym_stb on a non-accepted cycle is ignored; it is not remembered.
- Capture (mode 1):
  - phase counter increments on every accepted beat.
  - Captures when phase == max(cfg_decim,1)-1, then wraps to 0.
  - Switching cfg_mode resets phase to 0 on the next cycle.
- Tagging a captured symbol with last = 1: any of
  - the captured beat carries s_axis_tlast;
  - pend_eop is set;
  - cfg_spp != 0 and sym_cnt >= cfg_spp-1. The >= comparison lets a shrinking cfg_spp terminate the packet immediately.
- Counter and flag updates:
  - On a capture with last=1: sym_cnt clears to 0 and pend_eop clears.
  - On any other capture: sym_cnt increments.
- pend_eop: set by an accepted, non-captured beat with tlast=1. If a capture with last=1 occurs in the same cycle, clear takes priority and pend_eop is not set.
- FIFO write: a capture writes {last, tdata}.
- FIFO output:
  - First-word fall-through registered output.
  - A symbol captured in cycle N is presented on m_axis at N+1 when the FIFO is empty.
  - Throughput is 1 symbol/cycle.
- FIFO read and output hold: pop on m_axis_tvalid & m_axis_tready. m_axis_tdata and m_axis_tlast are held stable while tvalid=1 and tready=0.
- Full/empty:
  - Simultaneous push and pop keeps fill_level constant, including at full.
  - m_axis_tvalid=0 when empty.
  - fill_level never exceeds 2^FIFO_DEPTH_LOG2.
- Backpressure (default): s_axis_tready = ~full & ~ce_rst & ~clear. No symbol is lost; full means fill_level == depth.
- Reset mid-packet: partial-packet state is discarded. The first symbol after reset starts a new packet with sym_cnt=0.

Optional Feature:
- Macro: AXIS_SYMBOL_DECIMATOR_DROP_ON_FULL_EN.
- When defined:
  - s_axis_tready = ~ce_rst & ~clear; it ignores full, for real-time radio streams.
  - A capture while full is discarded. Phase, sym_cnt and pend_eop still advance exactly as if it had been written.
  - Adds output port overflow_cnt [15:0]: increments per dropped symbol, saturates at 16'hFFFF, cleared by ce_rst/clear.
- When undefined: backpressure behaviour as above and no overflow_cnt port.

Test Plan:
- Mode 1, cfg_decim=4, cfg_spp=0, 16 accepted samples 0..15, tready=1 -> outputs 3,7,11,15, each one cycle after its capture; tlast=0 on all.
- Mode 1, cfg_decim=2, cfg_spp=3, 12 samples -> symbols 1,3,5 | 7,9,11, tlast on 5 and 11.
- Mode 0, sym_stb on beats 2 and 6, input tlast on beat 4 -> symbol from beat 6 has tlast=1. Tlast on a captured beat 2 instead -> beat 2 symbol tlast=1, pend_eop not set.
- Mode 1, cfg_decim=1, m_axis_tready=0 for 40 cycles -> fill_level reaches 32, s_axis_tready drops to 0. tready=1 -> 32 symbols drained in order, none lost.
- DROP_ON_FULL_EN: same stall with 40 captures -> s_axis_tready stays 1, overflow_cnt=8, first 32 symbols delivered.
- ce_rst asserted mid-packet with fill_level=5 -> next cycle fill_level=0, tvalid=0; cfg_spp=3 packet restarts from the first new capture.
